// File: rtl/expr_checker_if.sv
// ============================================================================
// Module : expr_checker_if
// Desc   : Byte-stream and status bundle between a byte source and expr_checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface expr_checker_if #(
  parameter int DEPTH_W = 4,
  parameter int POS_W   = 8
);
  logic               restart;
  logic               in_valid;
  logic [7:0]         in;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [POS_W-1:0]   err_pos;

  modport master (
    output restart, in_valid, in,
    input  out, err, depth, err_pos
  );

  modport slave (
    input  restart, in_valid, in,
    output out, err, depth, err_pos
  );
endinterface

`default_nettype wire

// File: rtl/expr_checker.sv
// ============================================================================
// Module : expr_checker
// Desc   : Streaming recogniser for '+'/'*' infix expressions with parentheses.
//          Define SUB_DIV_EN to also accept '-' and '/' as operators.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module expr_checker #(
  parameter int MAX_DEPTH   = 4,
  parameter int DEPTH_W     = 4,
  parameter int POS_W       = 8,
  parameter int MULTI_DIGIT = 0
) (
  input  wire logic   clk,
  input  wire logic   clr_n,
  expr_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EXPECT  = 2'd0,
    ST_OPERAND = 2'd1,
    ST_ERR     = 2'd2
  } state_t;

  localparam logic [DEPTH_W-1:0] c_MAX_DEPTH = DEPTH_W'(MAX_DEPTH);
  localparam logic [POS_W-1:0]   c_POS_MAX   = {POS_W{1'b1}};

  state_t             r_state;
  state_t             w_next_state;
  logic [DEPTH_W-1:0] r_depth;
  logic [DEPTH_W-1:0] w_next_depth;
  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   r_err_pos;
  logic               r_out;
  logic               r_err;

  logic w_is_digit;
  logic w_is_op;
  logic w_is_lpar;
  logic w_is_rpar;

  assign w_is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign w_is_lpar  = (bus.in == 8'h28);
  assign w_is_rpar  = (bus.in == 8'h29);
`ifdef SUB_DIV_EN
  assign w_is_op    = (bus.in == 8'h2B) || (bus.in == 8'h2A) ||
                      (bus.in == 8'h2D) || (bus.in == 8'h2F);
`else
  assign w_is_op    = (bus.in == 8'h2B) || (bus.in == 8'h2A);
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_depth = r_depth;
    case (r_state)
      ST_EXPECT: begin
        if (w_is_digit) begin
          w_next_state = ST_OPERAND;
        end else if (w_is_lpar && (r_depth < c_MAX_DEPTH)) begin
          w_next_depth = r_depth + DEPTH_W'(1);
        end else begin
          w_next_state = ST_ERR;
        end
      end
      ST_OPERAND: begin
        if (w_is_op) begin
          w_next_state = ST_EXPECT;
        end else if (w_is_rpar && (r_depth != '0)) begin
          w_next_depth = r_depth - DEPTH_W'(1);
        end else if (w_is_digit && (MULTI_DIGIT != 0)) begin
          w_next_state = ST_OPERAND;
        end else begin
          w_next_state = ST_ERR;
        end
      end
      default: w_next_state = ST_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_EXPECT;
      r_depth   <= '0;
      r_pos     <= '0;
      r_err_pos <= '0;
      r_out     <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.restart) begin
      r_state   <= ST_EXPECT;
      r_depth   <= '0;
      r_pos     <= '0;
      r_err_pos <= '0;
      r_out     <= 1'b0;
      r_err     <= 1'b0;
    end else if (bus.in_valid) begin
      r_state <= w_next_state;
      r_depth <= w_next_depth;
      if (r_pos != c_POS_MAX) begin
        r_pos <= r_pos + POS_W'(1);
      end
      // Only the first offending byte is recorded; ERR is absorbing.
      if ((w_next_state == ST_ERR) && (r_state != ST_ERR)) begin
        r_err_pos <= r_pos;
      end
      r_out <= (w_next_state == ST_OPERAND) && (w_next_depth == '0);
      r_err <= (w_next_state == ST_ERR);
    end
  end

  assign bus.out     = r_out;
  assign bus.err     = r_err;
  assign bus.depth   = r_depth;
  assign bus.err_pos = r_err_pos;

endmodule

`default_nettype wire

// File: tb/tb_expr_checker.sv
// ============================================================================
// Module : tb_expr_checker
// Desc   : Directed bench; DUT A (MAX_DEPTH=2, single digit), DUT B (MAX_DEPTH=4, multi digit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_expr_checker;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  expr_checker_if #(.DEPTH_W(4), .POS_W(8)) ifa ();
  expr_checker_if #(.DEPTH_W(4), .POS_W(8)) ifb ();

  expr_checker #(.MAX_DEPTH(2), .DEPTH_W(4), .POS_W(8), .MULTI_DIGIT(0)) u_dut_a (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifa)
  );

  expr_checker #(.MAX_DEPTH(4), .DEPTH_W(4), .POS_W(8), .MULTI_DIGIT(1)) u_dut_b (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifb)
  );

  typedef struct {
    logic       rs;
    logic       v;
    logic [7:0] ch;
    logic       ao;
    logic       ae;
    int         ad;
    int         ap;
    logic       bo;
    logic       be;
    int         bd;
    int         bp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic rs, input logic v, input logic [7:0] ch,
                     input logic ao, input logic ae, input int ad, input int ap,
                     input logic bo, input logic be, input int bd, input int bp);
    vec_t e;
    e.rs = rs; e.v = v; e.ch = ch;
    e.ao = ao; e.ae = ae; e.ad = ad; e.ap = ap;
    e.bo = bo; e.be = be; e.bd = bd; e.bp = bp;
    tbl.push_back(e);
  endtask

  // Same expectation on both DUTs.
  task automatic add2(input logic v, input logic [7:0] ch,
                      input logic o, input logic e, input int d, input int p);
    add(1'b0, v, ch, o, e, d, p, o, e, d, p);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic v, input logic [7:0] ch);
    @(negedge clk);
    ifa.restart = rs; ifa.in_valid = v; ifa.in = ch;
    ifb.restart = rs; ifb.in_valid = v; ifb.in = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic ao, input logic ae, input int ad, input int ap,
                         input logic bo, input logic be, input int bd, input int bp);
    chk({tag, " a.out"},     int'(ifa.out),     int'(ao));
    chk({tag, " a.err"},     int'(ifa.err),     int'(ae));
    chk({tag, " a.depth"},   int'(ifa.depth),   ad);
    chk({tag, " a.err_pos"}, int'(ifa.err_pos), ap);
    chk({tag, " b.out"},     int'(ifb.out),     int'(bo));
    chk({tag, " b.err"},     int'(ifb.err),     int'(be));
    chk({tag, " b.depth"},   int'(ifb.depth),   bd);
    chk({tag, " b.err_pos"}, int'(ifb.err_pos), bp);
  endtask

  initial begin
    ifa.restart = 1'b0; ifa.in_valid = 1'b0; ifa.in = 8'h00;
    ifb.restart = 1'b0; ifb.in_valid = 1'b0; ifb.in = 8'h00;

    // "1+2*3"
    add2(1, "1", 1, 0, 0, 0);
    add2(1, "+", 0, 0, 0, 0);
    add2(1, "2", 1, 0, 0, 0);
    add2(1, "*", 0, 0, 0, 0);
    add2(1, "3", 1, 0, 0, 0);
    // restart with a byte: byte dropped
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    add2(1, "9", 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    // "((1))"
    add2(1, "(", 0, 0, 1, 0);
    add2(1, "(", 0, 0, 2, 0);
    add2(1, "1", 0, 0, 2, 0);
    add2(1, ")", 0, 0, 1, 0);
    add2(1, ")", 1, 0, 0, 0);
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    // "(((1": A overflows its nesting limit at index 2
    add2(1, "(", 0, 0, 1, 0);
    add2(1, "(", 0, 0, 2, 0);
    add(0, 1, "(", 0, 1, 2, 2, 0, 0, 3, 0);
    add(0, 1, "1", 0, 1, 2, 2, 0, 0, 3, 0);
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    // ")" first
    add2(1, ")", 0, 1, 0, 0);
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    // "1+)1"
    add2(1, "1", 1, 0, 0, 0);
    add2(1, "+", 0, 0, 0, 0);
    add2(1, ")", 0, 1, 0, 2);
    add2(1, "1", 0, 1, 0, 2);
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    // "12+345"
    add2(1, "1", 1, 0, 0, 0);
    add(0, 1, "2", 0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, "+", 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, "3", 0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, "4", 0, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, "5", 0, 1, 0, 1, 1, 0, 0, 0);
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    // "1+2" with idle gaps carrying bytes that must be ignored
    add2(1, "1", 1, 0, 0, 0);
    add2(0, ")", 1, 0, 0, 0);
    add2(1, "+", 0, 0, 0, 0);
    add2(0, "(", 0, 0, 0, 0);
    add2(1, "2", 1, 0, 0, 0);
    add(1, 1, "9", 0, 0, 0, 0, 0, 0, 0, 0);
    // "8-2/1"
    add2(1, "8", 1, 0, 0, 0);
`ifdef SUB_DIV_EN
    add2(1, "-", 0, 0, 0, 0);
    add2(1, "2", 1, 0, 0, 0);
    add2(1, "/", 0, 0, 0, 0);
    add2(1, "1", 1, 0, 0, 0);
`else
    add2(1, "-", 0, 1, 0, 1);
    add2(1, "2", 0, 1, 0, 1);
    add2(1, "/", 0, 1, 0, 1);
    add2(1, "1", 0, 1, 0, 1);
`endif

    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].v, tbl[i].ch);
      chk_all($sformatf("vec%0d", i), tbl[i].ao, tbl[i].ae, tbl[i].ad, tbl[i].ap,
              tbl[i].bo, tbl[i].be, tbl[i].bd, tbl[i].bp);
    end

    // Position counter saturation: error at index 301 reports 255
    step(1, 0, 8'h00);
    for (int k = 0; k < 150; k++) begin
      step(0, 1, "1");
      step(0, 1, "+");
    end
    step(0, 1, "1");
    chk_all("sat_pre", 1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, ")");
    chk_all("sat_err", 0, 1, 0, 255, 0, 1, 0, 255);

    // Asynchronous clear mid-string
    step(1, 0, 8'h00);
    step(0, 1, "(");
    step(0, 1, "1");
    step(0, 1, "+");
    step(0, 1, ")");
    chk_all("pre_clr", 0, 1, 1, 3, 0, 1, 1, 3);
    @(negedge clk);
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    chk_all("async_clr", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clr_n = 1'b1;
    step(0, 1, ")");
    chk_all("post_clr", 0, 1, 0, 0, 0, 1, 0, 0);

    step(0, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
